// File: rtl/motion_detector_pipe_if.sv
// motion_detector_pipe_if: input beat stream and output mask stream of motion_detector_pipe.
// Latency: none, wiring only.
// Backpressure: valid/ready on both streams; in_ready driven by the block, out_ready by the consumer.
interface motion_detector_pipe_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_sof;
  logic                   in_eof;
  logic [LANES*PIX_W-1:0] in_curr;
  logic [LANES*PIX_W-1:0] in_prev;
  logic [LANES*PIX_W-1:0] in_bg;
  logic [LANES*PIX_W-1:0] in_var;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0]       out_mask;
  logic                   out_sof;
  logic                   out_eof;

  // Producer / consumer side (pixel fetch in, motion-map writer out)
  modport master (
    output in_valid, in_sof, in_eof, in_curr, in_prev, in_bg, in_var, out_ready,
    input  in_ready, out_valid, out_mask, out_sof, out_eof
  );

  // Detector side
  modport slave (
    input  in_valid, in_sof, in_eof, in_curr, in_prev, in_bg, in_var, out_ready,
    output in_ready, out_valid, out_mask, out_sof, out_eof
  );
endinterface

// File: rtl/motion_detector_pipe.sv
// motion_detector_pipe: per-lane motion mask from frame-difference and background-difference tests.
// Latency: 2 cycles from input accept to out_valid (stage 1 flags, stage 2 mask).
// Backpressure: stage 2 holds while out_valid && !out_ready; in_ready = !s1_valid || s1_adv, no skid.
// Optional per-frame motion pixel counter enabled by defining MD_FRAME_STATS_EN.
module motion_detector_pipe #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        cfg_mode,
  input  logic [PIX_W-1:0]  threshold,
  motion_detector_pipe_if.slave bus,
  output logic [CNT_W-1:0]  frame_motion_count,
  output logic              frame_count_valid
);

  // Magnitude of a difference without wrap: subtract the smaller from the larger.
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Stage 1 registers: per-lane flags plus the per-beat configuration and frame markers
  logic             s1_valid;
  logic [LANES-1:0] s1_pf;
  logic [LANES-1:0] s1_bf;
  logic             s1_en;
  logic [1:0]       s1_mode;
  logic             s1_sof;
  logic             s1_eof;

  // Stage 2 registers drive the output stream directly
  logic             s2_valid;
  logic [LANES-1:0] out_mask_q;
  logic             out_sof_q;
  logic             out_eof_q;

  logic             s1_adv;
  logic             in_acc;
  logic [LANES-1:0] pf_d;
  logic [LANES-1:0] bf_d;
  logic [LANES-1:0] mask_d;

  assign s1_adv       = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign in_acc       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = s2_valid;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;

  // Per-lane pixel-difference and background-difference flags for the incoming beat
  always_comb begin
    pf_d = '0;
    bf_d = '0;
    for (int i = 0; i < LANES; i++) begin
      pf_d[i] = abs_diff(bus.in_curr[i*PIX_W +: PIX_W], bus.in_prev[i*PIX_W +: PIX_W]) > threshold;
      bf_d[i] = abs_diff(bus.in_curr[i*PIX_W +: PIX_W], bus.in_bg[i*PIX_W +: PIX_W])
                >= bus.in_var[i*PIX_W +: PIX_W];
    end
  end

  // Combine the stage 1 flags using the mode and enable sampled with that beat
  always_comb begin
    mask_d = '0;
    if (s1_en) begin
      case (s1_mode)
        2'd0:    mask_d = s1_pf & s1_bf;
        2'd1:    mask_d = s1_pf;
        2'd2:    mask_d = s1_bf;
        default: mask_d = s1_pf | s1_bf;
      endcase
    end
  end

  // Stage 1: capture flags on accept, empty out when the beat moves on with nothing behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_pf    <= '0;
      s1_bf    <= '0;
      s1_en    <= 1'b0;
      s1_mode  <= 2'd0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (in_acc) begin
      s1_valid <= 1'b1;
      s1_pf    <= pf_d;
      s1_bf    <= bf_d;
      s1_en    <= enable;
      s1_mode  <= cfg_mode;
      s1_sof   <= bus.in_sof;
      s1_eof   <= bus.in_eof;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: advance when the output slot is free or being consumed; otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_mask_q <= '0;
      out_sof_q  <= 1'b0;
      out_eof_q  <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_mask_q <= mask_d;
        out_sof_q  <= s1_sof;
        out_eof_q  <= s1_eof;
      end
    end
  end

`ifdef MD_FRAME_STATS_EN
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic             out_hs;
  logic [PC_W-1:0]  mask_pop;
  logic [SUM_W-1:0] acc_sum;
  logic [CNT_W-1:0] acc_next;
  logic [CNT_W-1:0] acc_q;

  assign out_hs = s2_valid && bus.out_ready;

  // Popcount of the beat currently on the output
  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      mask_pop = mask_pop + PC_W'(out_mask_q[i]);
    end
  end

  // Running total including this beat; sof restarts the frame, result saturates
  always_comb begin
    acc_sum  = (out_sof_q ? '0 : SUM_W'(acc_q)) + SUM_W'(mask_pop);
    acc_next = (acc_sum > CNT_MAX) ? {CNT_W{1'b1}} : acc_sum[CNT_W-1:0];
  end

  // Accumulate on output handshakes, publish and clear at eof with a one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q              <= '0;
      frame_motion_count <= '0;
      frame_count_valid  <= 1'b0;
    end else begin
      frame_count_valid <= out_hs && out_eof_q;
      if (out_hs) begin
        acc_q <= out_eof_q ? '0 : acc_next;
        if (out_eof_q) begin
          frame_motion_count <= acc_next;
        end
      end
    end
  end
`else
  assign frame_motion_count = '0;
  assign frame_count_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_motion_detector_pipe.sv
// tb_motion_detector_pipe: scoreboard bench for motion_detector_pipe (LANES=4, CNT_W=3).
// Expected beats are queued on input accept and compared on output handshake.
// Frame statistics are modelled when MD_FRAME_STATS_EN is defined, otherwise checked as tied to 0.
module tb_motion_detector_pipe;
  localparam int PIX_W   = 8;
  localparam int LANES   = 4;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef MD_FRAME_STATS_EN
  localparam int EXP7 = 7;
  localparam int EXP1 = 1;
  localparam int EXPS = 7;
`else
  localparam int EXP7 = 0;
  localparam int EXP1 = 0;
  localparam int EXPS = 0;
`endif

  typedef struct packed {
    logic [LANES-1:0] mask;
    logic             sof;
    logic             eof;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable;
  logic [1:0]       cfg_mode;
  logic [PIX_W-1:0] threshold;
  logic [CNT_W-1:0] frame_motion_count;
  logic             frame_count_valid;
  logic             ready_force;
  logic             rnd_en;
  logic             rnd_ready;
  logic [LANES*PIX_W-1:0] t_curr, t_prev, t_bg, t_var;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  motion_detector_pipe_if #(.PIX_W(PIX_W), .LANES(LANES)) bus ();

  motion_detector_pipe #(.PIX_W(PIX_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .cfg_mode           (cfg_mode),
    .threshold          (threshold),
    .bus                (bus),
    .frame_motion_count (frame_motion_count),
    .frame_count_valid  (frame_count_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign bus.out_ready = rnd_en ? rnd_ready : ready_force;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference mask straight from the detection rules
  function automatic logic [LANES-1:0] model_mask(input logic [LANES*PIX_W-1:0] c, p, b, v,
                                                  input logic en, input logic [1:0] mode,
                                                  input int thr);
    logic [LANES-1:0] m;
    int cv, pv, bv, vv, pd, bd;
    bit pf, bf;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      cv = c[i*PIX_W +: PIX_W];
      pv = p[i*PIX_W +: PIX_W];
      bv = b[i*PIX_W +: PIX_W];
      vv = v[i*PIX_W +: PIX_W];
      pd = (cv > pv) ? cv - pv : pv - cv;
      bd = (cv > bv) ? cv - bv : bv - cv;
      pf = (pd > thr);
      bf = (bd >= vv);
      if (en) begin
        case (mode)
          2'd0: m[i] = pf && bf;
          2'd1: m[i] = pf;
          2'd2: m[i] = bf;
          default: m[i] = pf || bf;
        endcase
      end
    end
    return m;
  endfunction

  task automatic set_lane(input int i, input int c, input int p, input int b, input int v);
    t_curr[i*PIX_W +: PIX_W] = c[PIX_W-1:0];
    t_prev[i*PIX_W +: PIX_W] = p[PIX_W-1:0];
    t_bg[i*PIX_W +: PIX_W]   = b[PIX_W-1:0];
    t_var[i*PIX_W +: PIX_W]  = v[PIX_W-1:0];
  endtask

  // Lanes set in m get a pixel that moves under every mode; others stay still
  task automatic set_motion(input logic [LANES-1:0] m);
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) set_lane(i, 200, 0, 0, 0);
      else      set_lane(i, 50, 50, 50, 10);
    end
  endtask

  function automatic int clip(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  // Present one beat, queue its expected result when accepted; returns at posedge+1 of the accept
  task automatic send(input logic sof, input logic eof);
    bit   acc;
    int   n;
    exp_t e;
    bus.in_curr  = t_curr;
    bus.in_prev  = t_prev;
    bus.in_bg    = t_bg;
    bus.in_var   = t_var;
    bus.in_sof   = sof;
    bus.in_eof   = eof;
    bus.in_valid = 1'b1;
    acc = 0;
    n   = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) begin
        e.mask = model_mask(t_curr, t_prev, t_bg, t_var, enable, cfg_mode, int'(threshold));
        e.sof  = sof;
        e.eof  = eof;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard pop, stall stability, frame statistics
  logic             stall_prev;
  logic [LANES-1:0] mask_prev;
  logic             sof_prev, eof_prev;
  int               acc_m, cnt_hold, pc, sum;
  bit               pend;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 0;
      acc_m      = 0;
      cnt_hold   = 0;
      pend       = 0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_mask", bus.out_mask, mask_prev);
        check("hold_sof", bus.out_sof, sof_prev);
        check("hold_eof", bus.out_eof, eof_prev);
      end
`ifdef MD_FRAME_STATS_EN
      check("frame_count_valid", frame_count_valid, pend);
      check("frame_motion_count", frame_motion_count, cnt_hold);
`else
      check("frame_count_valid", frame_count_valid, 0);
      check("frame_motion_count", frame_motion_count, 0);
`endif
      pend = 0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_mask", bus.out_mask, e.mask);
          check("out_sof", bus.out_sof, e.sof);
          check("out_eof", bus.out_eof, e.eof);
          pc  = $countones(e.mask);
          sum = (e.sof ? 0 : acc_m) + pc;
          if (sum > CNT_MAX) sum = CNT_MAX;
          if (e.eof) begin
            cnt_hold = sum;
            pend     = 1;
            acc_m    = 0;
          end else begin
            acc_m = sum;
          end
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      mask_prev  = bus.out_mask;
      sof_prev   = bus.out_sof;
      eof_prev   = bus.out_eof;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, flen, nb, cv;
    enable = 1; cfg_mode = 0; threshold = 10;
    ready_force = 1; rnd_en = 0;
    bus.in_valid = 0; bus.in_sof = 0; bus.in_eof = 0;
    bus.in_curr = '0; bus.in_prev = '0; bus.in_bg = '0; bus.in_var = '0;
    t_curr = '0; t_prev = '0; t_bg = '0; t_var = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_mask", bus.out_mask, 0);
    check("rst_out_sof", bus.out_sof, 0);
    check("rst_count", frame_motion_count, 0);
    check("rst_count_valid", frame_count_valid, 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Boundary lanes, mode 0, threshold 10, with latency check
    set_lane(0, 100, 111, 90, 10);
    set_lane(1, 100, 110, 90, 10);
    set_lane(2, 100, 111, 91, 10);
    set_lane(3, 200, 0, 0, 0);
    send(1, 0);
    @(negedge clk);
    check("lat_stage1", bus.out_valid, 0);
    @(negedge clk);
    check("lat_stage2", bus.out_valid, 1);
    check("tp_mask", bus.out_mask, 4'b1001);
    @(posedge clk);
    #1;

    // Mode sweep (pf=1, bf=0 on every lane), mode flips each beat, full throughput
    for (int i = 0; i < LANES; i++) set_lane(i, 100, 120, 95, 10);
    c0 = cyc;
    for (int m = 0; m < 4; m++) begin
      cfg_mode = m[1:0];
      send(0, 0);
    end
    check("throughput", cyc - c0, 4);
    cfg_mode = 2'd1;
    threshold = 8'hFF;
    for (int i = 0; i < LANES; i++) set_lane(i, 255, 0, 0, 0);
    send(0, 0);
    threshold = 10;

    // Detection disabled: full-motion beat yields an all-zero mask, markers forwarded
    wait_drain();
    cfg_mode = 2'd3;
    enable   = 0;
    set_motion(4'b1111);
    send(1, 1);
    enable = 1;
    @(negedge clk);
    @(negedge clk);
    check("en0_valid", bus.out_valid, 1);
    check("en0_mask", bus.out_mask, 4'b0000);
    check("en0_sof", bus.out_sof, 1);
    check("en0_eof", bus.out_eof, 1);
    @(posedge clk);
    #1;

    // Backpressure: two beats fill both stages, input stalls, output holds
    wait_drain();
    ready_force = 0;
    set_motion(4'b0101);
    send(0, 0);
    set_motion(4'b1010);
    send(0, 0);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_mask", bus.out_mask, 4'b0101);
    end
    @(posedge clk);
    #1;
    ready_force = 1;
    set_motion(4'b0011);
    send(0, 0);
    wait_drain();

    // Random traffic with random downstream ready, framed with sof/eof
    rnd_en = 1;
    nb = 0;
    while (nb < 1000) begin
      flen = $urandom_range(1, 8);
      for (int j = 0; j < flen; j++) begin
        for (int i = 0; i < LANES; i++) begin
          cv = $urandom_range(0, 255);
          set_lane(i, cv, clip(cv + $urandom_range(0, 40) - 20),
                   clip(cv + $urandom_range(0, 40) - 20), $urandom_range(0, 30));
        end
        cfg_mode  = 2'($urandom_range(0, 3));
        enable    = ($urandom_range(0, 7) != 0);
        threshold = 8'($urandom_range(0, 30));
        send(j == 0, j == flen - 1);
        nb++;
      end
    end
    wait_drain();
    rnd_en = 0;
    enable = 1; cfg_mode = 2'd3; threshold = 10;

    // Frame statistics: 3-beat frame, single-beat frame, saturating frame
    set_motion(4'b1011); send(1, 0);
    set_motion(4'b0000); send(0, 0);
    set_motion(4'b1111); send(0, 1);
    wait_drain();
    check("frame_of_7", frame_motion_count, EXP7);
    set_motion(4'b0001); send(1, 1);
    wait_drain();
    check("frame_single", frame_motion_count, EXP1);
    set_motion(4'b1111);
    send(1, 0);
    send(0, 0);
    send(0, 1);
    wait_drain();
    check("frame_saturate", frame_motion_count, EXPS);

    // Reset with two beats in flight
    ready_force = 0;
    set_motion(4'b1111);
    send(1, 0);
    send(0, 0);
    @(negedge clk);
    check("inflight_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_mask", bus.out_mask, 0);
    check("arst_count", frame_motion_count, 0);
    check("arst_count_valid", frame_count_valid, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    ready_force = 1;
    repeat (5) begin
      @(negedge clk);
      check("no_stale_beat", bus.out_valid, 0);
    end
    check("post_rst_count", frame_motion_count, 0);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
